uart_cmd_rx: RTL and testbench

UART command receiver that sits directly upstream of the divider register file. It deserialises bytes from the board-level serial input `uart_rx_i` and assembles them into framed register commands. It then drives the register command port (`cmd_opt` / `cmd_addr` / `cmd_data`) with a single-cycle command strobe. For reads, it captures the register file's read data one cycle after issuing the command.

---
 rtl/uart_cmd_rx.sv | 235 +++++++++++++++++++++++
 tb/tb_uart_cmd_rx.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_rx.sv
// rtl/uart_cmd_rx.sv - UART 8N1 receiver and register command framer; optional inter-byte timeout under UART_CMD_TIMEOUT_EN
module uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic                  clk_i,
  input  logic                  rst,
  input  logic                  uart_rx_i,
  output logic [1:0]            cmd_opt_o,
  output logic [ADDR_WIDTH-1:0] cmd_addr_o,
  output logic [DATA_WIDTH-1:0] cmd_data_o,
  input  logic [DATA_WIDTH-1:0] cmd_rdata_i,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_vld_o,
  output logic                  frm_err_o
);

  localparam int CW     = $clog2(CLKS_PER_BIT);
  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int BCW    = $clog2(NBYTES + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {P_HUNT, P_OPC, P_ADDR, P_DATA, P_ISSUE} p_state_t;

  logic            sync1_q, sync2_q, sync3_q;
  rx_state_t       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            byte_vld_q, byte_vld_d;
  logic            rx_ferr_q, rx_ferr_d;

  p_state_t              p_state_q, p_state_d;
  logic                  is_rd_q, is_rd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [BCW-1:0]        bcnt_q, bcnt_d;
  logic                  bad_opc;
  logic                  timeout;

  logic [ADDR_WIDTH-1:0] cmd_addr_q;
  logic [DATA_WIDTH-1:0] cmd_data_q, rsp_data_q;
  logic                  rsp_vld_q, frm_err_q;

  // Two-flop synchroniser plus one history flop for falling-edge detection
  always_ff @(posedge clk_i) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= uart_rx_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // Bit receiver next-state: mid-bit sampling, counter restarts on every state change
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    byte_vld_d = 1'b0;
    rx_ferr_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (sync3_q && !sync2_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == HALF_M1) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == FULL_M1) begin
          rx_cnt_d   = '0;
          rx_shift_d = {sync2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == FULL_M1) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          byte_vld_d = sync2_q;
          rx_ferr_d  = !sync2_q;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Bit receiver state registers
  always_ff @(posedge clk_i) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      byte_vld_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      byte_vld_q <= byte_vld_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TOW       = $clog2(TO_CYCLES + 1);
  logic [TOW-1:0] to_cnt_q, to_cnt_d;
  logic           in_frame;

  assign in_frame = (p_state_q == P_OPC) || (p_state_q == P_ADDR) || (p_state_q == P_DATA);

  // Inter-byte timer: counts only while a frame is open and the line is idle
  always_comb begin
    to_cnt_d = to_cnt_q;
    timeout  = 1'b0;
    if (byte_vld_q || !in_frame) begin
      to_cnt_d = '0;
    end else if (rx_state_q == RX_IDLE) begin
      if (to_cnt_q == TOW'(TO_CYCLES - 1)) begin
        timeout  = 1'b1;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  // Inter-byte timer register
  always_ff @(posedge clk_i) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`else
  // Timeout is never raised in this build; a partial frame waits indefinitely
  assign timeout = (TIMEOUT_BITS < 0);
`endif

  // Frame parser next-state; UART framing errors and timeouts abort to HUNT
  always_comb begin
    p_state_d = p_state_q;
    is_rd_d   = is_rd_q;
    addr_d    = addr_q;
    data_d    = data_q;
    bcnt_d    = bcnt_q;
    bad_opc   = 1'b0;
    case (p_state_q)
      P_HUNT: begin
        if (byte_vld_q && rx_shift_q == 8'hA5) p_state_d = P_OPC;
      end
      P_OPC: begin
        if (byte_vld_q) begin
          case (rx_shift_q)
            8'h57:   begin is_rd_d = 1'b0; p_state_d = P_ADDR; end
            8'h52:   begin is_rd_d = 1'b1; p_state_d = P_ADDR; end
            8'hA5:   p_state_d = P_OPC;
            default: begin bad_opc = 1'b1; p_state_d = P_HUNT; end
          endcase
        end
      end
      P_ADDR: begin
        if (byte_vld_q) begin
          addr_d    = rx_shift_q[ADDR_WIDTH-1:0];
          bcnt_d    = '0;
          p_state_d = is_rd_q ? P_ISSUE : P_DATA;
        end
      end
      P_DATA: begin
        if (byte_vld_q) begin
          data_d = (data_q << 8) | DATA_WIDTH'(rx_shift_q);
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == BCW'(NBYTES - 1)) p_state_d = P_ISSUE;
        end
      end
      P_ISSUE: begin
        p_state_d = (byte_vld_q && rx_shift_q == 8'hA5) ? P_OPC : P_HUNT;
      end
      default: p_state_d = P_HUNT;
    endcase
    if (rx_ferr_q || timeout) p_state_d = P_HUNT;
  end

  // Parser registers, held command outputs, read capture and error pulse
  always_ff @(posedge clk_i) begin
    if (rst) begin
      p_state_q  <= P_HUNT;
      is_rd_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      bcnt_q     <= '0;
      cmd_addr_q <= '0;
      cmd_data_q <= '0;
      rsp_data_q <= '0;
      rsp_vld_q  <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      p_state_q <= p_state_d;
      is_rd_q   <= is_rd_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      bcnt_q    <= bcnt_d;
      if (p_state_d == P_ISSUE && p_state_q != P_ISSUE) begin
        cmd_addr_q <= addr_d;
        if (!is_rd_d) cmd_data_q <= data_d;
      end
      rsp_vld_q <= (p_state_q == P_ISSUE) && is_rd_q;
      if (p_state_q == P_ISSUE && is_rd_q) rsp_data_q <= cmd_rdata_i;
      frm_err_q <= rx_ferr_q || bad_opc || timeout;
    end
  end

  assign cmd_opt_o  = (p_state_q == P_ISSUE) ? (is_rd_q ? 2'b10 : 2'b01) : 2'b00;
  assign cmd_addr_o = cmd_addr_q;
  assign cmd_data_o = cmd_data_q;
  assign rsp_data_o = rsp_data_q;
  assign rsp_vld_o  = rsp_vld_q;
  assign frm_err_o  = frm_err_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb/tb_uart_cmd_rx.sv - scoreboard bench for uart_cmd_rx (CLKS_PER_BIT=16)
module tb_uart_cmd_rx;
  localparam int CPB = 16;

  logic        clk_i = 1'b0;
  logic        rst;
  logic        uart_rx_i;
  logic [1:0]  cmd_opt_o;
  logic [7:0]  cmd_addr_o;
  logic [31:0] cmd_data_o;
  logic [31:0] cmd_rdata_i;
  logic [31:0] rsp_data_o;
  logic        rsp_vld_o;
  logic        frm_err_o;

  uart_cmd_rx #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT_BITS(32)) dut (
    .clk_i(clk_i), .rst(rst), .uart_rx_i(uart_rx_i),
    .cmd_opt_o(cmd_opt_o), .cmd_addr_o(cmd_addr_o), .cmd_data_o(cmd_data_o),
    .cmd_rdata_i(cmd_rdata_i), .rsp_data_o(rsp_data_o), .rsp_vld_o(rsp_vld_o),
    .frm_err_o(frm_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [1:0]  opt;
    logic [7:0]  addr;
    logic [31:0] data;
  } cmd_t;
  typedef logic [7:0] bq_t [$];

  cmd_t        exp_q [$];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          err_cnt = 0;
  int          cmd_cnt = 0;
  logic        rd_pend = 1'b0;
  logic [31:0] rd_exp = '0;
  logic [1:0]  prev_opt = 2'b00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx_i = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = b[i];
      tick(CPB);
    end
    uart_rx_i = stop;
    tick(CPB);
    uart_rx_i = 1'b1;
  endtask

  task automatic send_bytes(input bq_t bs);
    foreach (bs[i]) send_byte(bs[i], 1'b1);
  endtask

  // Output monitor: pops the scoreboard on each command strobe
  always @(negedge clk_i) begin
    cmd_t e;
    if (rst) begin
      rd_pend  = 1'b0;
      prev_opt = 2'b00;
    end else begin
      if (frm_err_o) err_cnt++;
      if (rd_pend) begin
        check("rsp_vld", 32'(rsp_vld_o), 32'd1);
        check("rsp_data", rsp_data_o, rd_exp);
        rd_pend = 1'b0;
      end else if (rsp_vld_o) begin
        check("rsp_vld_spurious", 32'(rsp_vld_o), 32'd0);
      end
      if (cmd_opt_o != 2'b00) begin
        cmd_cnt++;
        check("no_err_with_cmd", 32'(frm_err_o), 32'd0);
        check("strobe_width", 32'(prev_opt), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_cmd", 32'(cmd_opt_o), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("cmd_opt", 32'(cmd_opt_o), 32'(e.opt));
          check("cmd_addr", 32'(cmd_addr_o), 32'(e.addr));
          if (e.opt == 2'b01) begin
            check("cmd_data", cmd_data_o, e.data);
          end else begin
            rd_pend = 1'b1;
            rd_exp  = e.data;
          end
        end
      end
      prev_opt = cmd_opt_o;
    end
  end

  initial begin
    bq_t fr;
    int  e0;
    int  c0;
    rst         = 1'b1;
    uart_rx_i   = 1'b1;
    cmd_rdata_i = 32'hCAFEF00D;
    tick(3);
    check("rst_opt", 32'(cmd_opt_o), 32'd0);
    check("rst_addr", 32'(cmd_addr_o), 32'd0);
    check("rst_data", cmd_data_o, 32'd0);
    check("rst_rsp_data", rsp_data_o, 32'd0);
    check("rst_rsp_vld", 32'(rsp_vld_o), 32'd0);
    check("rst_frm_err", 32'(frm_err_o), 32'd0);
    rst = 1'b0;
    tick(4);

    exp_q.push_back({2'b01, 8'h10, 32'h12345678});
    fr = '{8'hA5, 8'h57, 8'h10, 8'h12, 8'h34, 8'h56, 8'h78};
    send_bytes(fr);
    tick(8);
    check("write_drained", 32'(exp_q.size()), 32'd0);
    check("write_cmd_cnt", 32'(cmd_cnt), 32'd1);
    check("write_no_err", 32'(err_cnt), 32'd0);
    check("write_addr_hold", 32'(cmd_addr_o), 32'h10);
    check("write_data_hold", cmd_data_o, 32'h12345678);

    exp_q.push_back({2'b10, 8'h04, 32'hCAFEF00D});
    fr = '{8'hA5, 8'h52, 8'h04};
    send_bytes(fr);
    tick(8);
    check("read_drained", 32'(exp_q.size()), 32'd0);
    check("read_cmd_cnt", 32'(cmd_cnt), 32'd2);
    check("read_rsp_hold", rsp_data_o, 32'hCAFEF00D);

    e0 = err_cnt;
    fr = '{8'hA5, 8'h33};
    send_bytes(fr);
    tick(8);
    check("bad_opc_err", 32'(err_cnt), 32'(e0 + 1));
    exp_q.push_back({2'b10, 8'h01, 32'hCAFEF00D});
    fr = '{8'hA5, 8'h52, 8'h01};
    send_bytes(fr);
    tick(8);
    check("after_err_read", 32'(cmd_cnt), 32'd3);

    e0 = err_cnt;
    send_byte(8'h55, 1'b0);
    tick(2 * CPB);
    check("stop_bit_err", 32'(err_cnt), 32'(e0 + 1));
    check("stop_bit_no_cmd", 32'(cmd_cnt), 32'd3);

    e0 = err_cnt;
    uart_rx_i = 1'b0;
    tick(4);
    uart_rx_i = 1'b1;
    tick(2 * CPB);
    check("glitch_no_err", 32'(err_cnt), 32'(e0));

    exp_q.push_back({2'b01, 8'h20, 32'h00000001});
    fr = '{8'h00, 8'hA5, 8'hA5, 8'h57, 8'h20, 8'h00, 8'h00, 8'h00, 8'h01};
    send_bytes(fr);
    tick(8);
    check("resync_drained", 32'(exp_q.size()), 32'd0);
    check("resync_cmd_cnt", 32'(cmd_cnt), 32'd4);

    fr = '{8'hA5, 8'h57, 8'h10, 8'h12};
    send_bytes(fr);
    rst = 1'b1;
    tick(1);
    check("mid_rst_opt", 32'(cmd_opt_o), 32'd0);
    check("mid_rst_addr", 32'(cmd_addr_o), 32'd0);
    check("mid_rst_data", cmd_data_o, 32'd0);
    check("mid_rst_rsp", rsp_data_o, 32'd0);
    check("mid_rst_vld", 32'(rsp_vld_o), 32'd0);
    check("mid_rst_err", 32'(frm_err_o), 32'd0);
    rst = 1'b0;
    tick(2);
    exp_q.push_back({2'b01, 8'h10, 32'hAABBCCDD});
    fr = '{8'hA5, 8'h57, 8'h10, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_bytes(fr);
    tick(8);
    check("post_rst_drained", 32'(exp_q.size()), 32'd0);
    check("post_rst_cmd_cnt", 32'(cmd_cnt), 32'd5);

    e0 = err_cnt;
    c0 = cmd_cnt;
    fr = '{8'hA5, 8'h57};
    send_bytes(fr);
    tick(32 * CPB + 32);
`ifdef UART_CMD_TIMEOUT_EN
    check("timeout_err", 32'(err_cnt), 32'(e0 + 1));
    fr = '{8'h10, 8'h12, 8'h34, 8'h56, 8'h78};
    send_bytes(fr);
    tick(8);
    check("timeout_no_cmd", 32'(cmd_cnt), 32'(c0));
`else
    check("no_timeout_err", 32'(err_cnt), 32'(e0));
    exp_q.push_back({2'b01, 8'h10, 32'h12345678});
    fr = '{8'h10, 8'h12, 8'h34, 8'h56, 8'h78};
    send_bytes(fr);
    tick(8);
    check("late_write_cmd", 32'(cmd_cnt), 32'(c0 + 1));
`endif
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
